sha256_msg_writer: RTL and testbench
====================================

// Module: sha256_msg_writer
// PURPOSE
//  Producer side of the SHA-256 engine's message-memory interface: accepts a fixed-length message
//  as a 32-bit word stream, writes it plus SHA-256 padding into memory at a base address, then
//  pulses the hasher's start and waits for its done. Sits between the header source and the
//  hasher; shares the same single-port memory (mem_clk/mem_we/mem_addr/mem_write_data).
// PARAMETERS
//  MSG_WORDS  20  message length in 32-bit words (1..1000); message bits L = MSG_WORDS*32
//  PAD_WORDS  ((MSG_WORDS+3+15)/16)*16  derived, localparam: total padded words, multiple of 16
// PORTS
//  clk             in   1   single clock; all state changes on posedge
//  reset           in   1   asynchronous, active-high reset
//  go              in   1   start request; sampled only in IDLE or DONE
//  message_addr    in   16  base word address, latched on accepted go
//  in_valid        in   1   stream word valid
//  in_ready        out  1   stream ready; combinational, =1 only in LOAD
//  in_data         in   32  stream word, big-endian word order (word 0 first)
//  mem_clk         out  1   = clk
//  mem_we          out  1   registered write enable
//  mem_addr        out  16  registered write address
//  mem_write_data  out  32  registered write data
//  hash_start      out  1   registered one-cycle start pulse to hasher
//  hash_done       in   1   hasher done (level)
//  busy            out  1   =1 in LOAD/PAD/KICK/WAIT
//  done            out  1   registered; high from hash completion until next accepted go
// BEHAVIOUR
//  Reset (any state, async): state=IDLE; mem_we, mem_addr, mem_write_data, hash_start, done,
//   word index all 0. A reset mid-LOAD/PAD abandons the message; no further writes issued.
//  States: IDLE -> LOAD -> PAD -> KICK -> WAIT -> DONE -> (go) LOAD.
//  IDLE/DONE: go=1 -> latch base=message_addr, idx=0, done<=0, -> LOAD. go ignored elsewhere.
//  LOAD: beat accepted when in_valid&in_ready. Accept at edge k -> write visible cycle k+1:
//   mem_we=1, mem_addr=base+idx, mem_write_data=in_data; idx++. Cycles without a beat: mem_we<=0.
//   Accept of word MSG_WORDS-1 -> PAD.
//  PAD: one write per cycle, no gaps, first pad write visible cycle after last message write:
//   idx=MSG_WORDS -> 32'h8000_0000; idx=PAD_WORDS-2 -> 32'h0 (L high word);
//   idx=PAD_WORDS-1 -> L (32-bit); all other idx -> 32'h0. After idx=PAD_WORDS-1 -> KICK.
//  KICK: mem_we<=0, hash_start<=1 (exactly one cycle), -> WAIT.
//  WAIT: hash_start<=0; hash_done=1 -> done<=1, -> DONE. hash_done ignored in all other states.
//  Address arithmetic mod 2^16 (base+idx wraps at 16'hFFFF -> 16'h0000).
//  mem_addr/mem_write_data hold last value when mem_we=0; never written outside LOAD/PAD.
//  Total writes per message exactly PAD_WORDS; addresses strictly ascending base..base+PAD_WORDS-1.
//  Latency (no stream gaps): go at edge 0 -> first write cycle 2 -> last write cycle PAD_WORDS+1
//   -> hash_start high cycle PAD_WORDS+2.
// TESTING
//  T1 MSG_WORDS=20, base=0x0000, continuous words 0x1000+i -> 32 writes addr 0..31; addr 20=0x80000000,
//     21..30=0, 31=0x00000280; hash_start one pulse cycle 34; hash_done after 10 cycles -> done=1.
//  T2 same, in_valid toggling 1-0-1-0 -> identical write contents/addresses, mem_we low in gap cycles,
//     pad writes contiguous after last message write.
//  T3 MSG_WORDS=13 -> 16 writes; addr 13=0x80000000, 14=0, 15=0x000001A0; single hash_start pulse.
//  T4 base=0xFFF8, MSG_WORDS=20 -> addresses wrap 0xFFF8..0xFFFF,0x0000..0x0017.
//  T5 go pulsed during LOAD and WAIT -> ignored; hash_done pulsed during LOAD -> ignored; done stays 0.
//  T6 reset asserted after 7 accepted words -> all outputs 0 same cycle (async), state IDLE; new go
//     restarts with idx=0 and full correct write sequence.

Source files
------------

// File: rtl/sha256_msg_writer.sv
// Writes a fixed-length message stream plus SHA-256 padding into the hasher's message memory,
// then kicks the hasher and waits for it to finish.
module sha256_msg_writer #(
   parameter int unsigned MSG_WORDS = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        go,
   input  logic [15:0] message_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        hash_start,
   input  logic        hash_done,
   output logic        busy,
   output logic        done
);

   localparam int unsigned PAD_WORDS = ((MSG_WORDS + 3 + 15) / 16) * 16;
   localparam logic [15:0] LAST_MSG  = 16'(MSG_WORDS - 1);
   localparam logic [15:0] MARK_IDX  = 16'(MSG_WORDS);
   localparam logic [15:0] LAST_PAD  = 16'(PAD_WORDS - 1);
   localparam logic [31:0] MSG_BITS  = 32'(MSG_WORDS * 32);

   typedef enum logic [2:0] {StIdle, StLoad, StPad, StKick, StWait, StDone} state_t;

   state_t      state_q;
   logic [15:0] base_q;
   logic [15:0] idx_q;
   logic [31:0] pad_word;

   assign mem_clk  = clk;
   assign in_ready = (state_q == StLoad);
   assign busy     = (state_q == StLoad) || (state_q == StPad) ||
                     (state_q == StKick) || (state_q == StWait);

   // The upper length word (index PAD_WORDS-2) is always zero since L fits in 32 bits.
   always_comb begin
      pad_word = 32'h0;
      if (idx_q == MARK_IDX) begin
         pad_word = 32'h8000_0000;
      end else if (idx_q == LAST_PAD) begin
         pad_word = MSG_BITS;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         base_q         <= 16'h0;
         idx_q          <= 16'h0;
         mem_we         <= 1'b0;
         mem_addr       <= 16'h0;
         mem_write_data <= 32'h0;
         hash_start     <= 1'b0;
         done           <= 1'b0;
      end else begin
         mem_we     <= 1'b0;
         hash_start <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (go) begin
                  base_q  <= message_addr;
                  idx_q   <= 16'h0;
                  done    <= 1'b0;
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               if (in_valid) begin
                  mem_we         <= 1'b1;
                  mem_addr       <= base_q + idx_q;
                  mem_write_data <= in_data;
                  idx_q          <= idx_q + 16'h1;
                  if (idx_q == LAST_MSG) begin
                     state_q <= StPad;
                  end
               end
            end
            StPad: begin
               mem_we         <= 1'b1;
               mem_addr       <= base_q + idx_q;
               mem_write_data <= pad_word;
               idx_q          <= idx_q + 16'h1;
               if (idx_q == LAST_PAD) begin
                  state_q <= StKick;
               end
            end
            StKick: begin
               hash_start <= 1'b1;
               state_q    <= StWait;
            end
            StWait: begin
               if (hash_done) begin
                  done    <= 1'b1;
                  state_q <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_writer.sv
// Directed bench for sha256_msg_writer: a 20-word instance and a 13-word instance.
module tb_sha256_msg_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] message_addr;
   logic        go [2];
   logic        in_valid [2];
   logic [31:0] in_data [2];
   logic        hash_done [2];
   logic        in_ready [2];
   logic        mem_clk [2];
   logic        mem_we [2];
   logic [15:0] mem_addr [2];
   logic [31:0] mem_write_data [2];
   logic        hash_start [2];
   logic        busy [2];
   logic        done [2];

   always #5 clk = ~clk;

   sha256_msg_writer #(.MSG_WORDS(20)) u_dut20 (
      .clk(clk), .reset(reset), .go(go[0]), .message_addr(message_addr),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .mem_clk(mem_clk[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_write_data(mem_write_data[0]), .hash_start(hash_start[0]),
      .hash_done(hash_done[0]), .busy(busy[0]), .done(done[0])
   );

   sha256_msg_writer #(.MSG_WORDS(13)) u_dut13 (
      .clk(clk), .reset(reset), .go(go[1]), .message_addr(message_addr),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .mem_clk(mem_clk[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_write_data(mem_write_data[1]), .hash_start(hash_start[1]),
      .hash_done(hash_done[1]), .busy(busy[1]), .done(done[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] wr_addr [64];
   logic [31:0] wr_data [64];
   int          wr_rel [64];
   int          wr_cnt, hs_cnt, hs_rel, done_rel;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Hand-derived memory image: message words, 0x80000000 marker, zeros, then L.
   function automatic logic [31:0] exp_word(input int sel, input int i);
      int words = (sel != 0) ? 13 : 20;
      int pad   = (sel != 0) ? 16 : 32;
      if (i < words) return 32'h1000 + 32'(i);
      if (i == words) return 32'h8000_0000;
      if (i == pad - 1) return (sel != 0) ? 32'h0000_01A0 : 32'h0000_0280;
      return 32'h0;
   endfunction

   // One message: pulse go, stream words, record writes/pulses, answer hash_start after 10 cycles.
   task automatic run(input int sel, input logic [15:0] base, input bit gap, input bit glitch,
                      input int rst_after, output bit aborted);
      int  words = (sel != 0) ? 13 : 20;
      int  rel;
      int  acc = 0;
      bit  fin = 1'b0;
      wr_cnt = 0; hs_cnt = 0; hs_rel = -1; done_rel = -1; aborted = 1'b0;
      @(negedge clk);
      message_addr = base;
      go[sel] = 1'b1;
      @(posedge clk);
      rel = 0;
      #1 go[sel] = 1'b0;
      while (!fin && !aborted && rel < 200) begin
         @(negedge clk);
         if (mem_we[sel]) begin
            if (wr_cnt < 64) begin
               wr_addr[wr_cnt] = mem_addr[sel];
               wr_data[wr_cnt] = mem_write_data[sel];
               wr_rel[wr_cnt]  = rel;
            end
            wr_cnt++;
         end
         if (hash_start[sel]) begin
            hs_cnt++;
            if (hs_rel < 0) hs_rel = rel;
         end
         if (done[sel]) begin
            done_rel = rel;
            fin = 1'b1;
         end
         if (rst_after > 0 && acc == rst_after) begin
            reset = 1'b1;
            #1;
            check("rst_mem_we", 32'(mem_we[sel]), 32'h0);
            check("rst_mem_addr", 32'(mem_addr[sel]), 32'h0);
            check("rst_mem_data", mem_write_data[sel], 32'h0);
            check("rst_hash_start", 32'(hash_start[sel]), 32'h0);
            check("rst_done", 32'(done[sel]), 32'h0);
            check("rst_busy", 32'(busy[sel]), 32'h0);
            check("rst_in_ready", 32'(in_ready[sel]), 32'h0);
            in_valid[sel] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            aborted = 1'b1;
         end else begin
            hash_done[sel] = (hs_rel >= 0) && (rel >= hs_rel + 10) && !fin;
            if (glitch) begin
               go[sel] = (rel == 3) || (hs_rel >= 0 && rel == hs_rel + 3);
               message_addr = go[sel] ? 16'h5555 : base;
               if (rel == 4) hash_done[sel] = 1'b1;
               if (rel == 6) begin
                  check("t5_done_low", 32'(done[sel]), 32'h0);
                  check("t5_busy", 32'(busy[sel]), 32'h1);
               end
            end
            in_valid[sel] = (acc < words) && (!gap || (rel % 2 == 0));
            in_data[sel]  = 32'h1000 + 32'(acc);
            #1;
            if (in_valid[sel] && in_ready[sel]) acc++;
            @(posedge clk);
            rel++;
         end
      end
      if (!fin && !aborted) check("timeout", 32'h0, 32'h1);
      in_valid[sel] = 1'b0;
      hash_done[sel] = 1'b0;
      go[sel] = 1'b0;
   endtask

   task automatic verify(input string t, input int sel, input logic [15:0] base, input bit gap);
      int words = (sel != 0) ? 13 : 20;
      int pad   = (sel != 0) ? 16 : 32;
      check({t, "_wr_count"}, 32'(wr_cnt), 32'(pad));
      for (int i = 0; i < pad && i < wr_cnt && i < 64; i++) begin
         check({t, "_addr"}, 32'(wr_addr[i]), 32'(16'(base + 16'(i))));
         check({t, "_data"}, wr_data[i], exp_word(sel, i));
         if (i >= words) check({t, "_pad_contig"}, 32'(wr_rel[i]), 32'(wr_rel[words - 1] + i - words + 1));
      end
      check({t, "_hs_pulses"}, 32'(hs_cnt), 32'h1);
      check({t, "_done_latency"}, 32'(done_rel), 32'(hs_rel + 11));
      check({t, "_busy_end"}, 32'(busy[sel]), 32'h0);
      if (!gap) begin
         check({t, "_first_wr_cycle"}, 32'(wr_rel[0] + 1), 32'd2);
         check({t, "_hs_cycle"}, 32'(hs_rel + 1), 32'(pad + 2));
      end
   endtask

   initial begin
      bit ab;
      reset = 1'b1;
      message_addr = 16'h0;
      for (int s = 0; s < 2; s++) begin
         go[s] = 1'b0; in_valid[s] = 1'b0; in_data[s] = 32'h0; hash_done[s] = 1'b0;
      end
      #1;
      check("reset_mem_we", 32'(mem_we[0]), 32'h0);
      check("reset_mem_addr", 32'(mem_addr[0]), 32'h0);
      check("reset_mem_data", mem_write_data[0], 32'h0);
      check("reset_hash_start", 32'(hash_start[0]), 32'h0);
      check("reset_done", 32'(done[0]), 32'h0);
      check("reset_busy", 32'(busy[0]), 32'h0);
      check("reset_in_ready", 32'(in_ready[0]), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // T1: continuous stream at base 0
      run(0, 16'h0000, 1'b0, 1'b0, 0, ab);
      verify("t1", 0, 16'h0000, 1'b0);
      check("t1_addr31_len", wr_data[31], 32'h0000_0280);
      check("t1_addr20_mark", wr_data[20], 32'h8000_0000);
      repeat (3) @(negedge clk);
      check("t1_done_held", 32'(done[0]), 32'h1);
      check("mem_clk_is_clk", 32'(mem_clk[0]), 32'(clk));

      // T2: valid toggling, writes spaced two cycles apart during LOAD
      run(0, 16'h0040, 1'b1, 1'b0, 0, ab);
      verify("t2", 0, 16'h0040, 1'b1);
      check("t2_gap_spacing", 32'(wr_rel[1] - wr_rel[0]), 32'd2);

      // T3: 13-word message pads to one 16-word block
      run(1, 16'h0200, 1'b0, 1'b0, 0, ab);
      verify("t3", 1, 16'h0200, 1'b0);
      check("t3_addr15_len", wr_data[15], 32'h0000_01A0);

      // T4: address wrap
      run(0, 16'hFFF8, 1'b0, 1'b0, 0, ab);
      verify("t4", 0, 16'hFFF8, 1'b0);
      check("t4_wrap_zero", 32'(wr_addr[8]), 32'h0000);
      check("t4_last_addr", 32'(wr_addr[31]), 32'h0017);

      // T5: go during LOAD/WAIT and hash_done during LOAD are ignored
      run(0, 16'h0300, 1'b0, 1'b1, 0, ab);
      verify("t5", 0, 16'h0300, 1'b0);

      // T6: reset after 7 accepted words, then a clean restart
      run(0, 16'h0100, 1'b0, 1'b0, 7, ab);
      check("t6_aborted", 32'(ab), 32'h1);
      check("t6_writes_before_rst", 32'(wr_cnt), 32'd7);
      run(0, 16'h0100, 1'b0, 1'b0, 0, ab);
      verify("t6", 0, 16'h0100, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
